uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter between NUM_REQ byte-producing clients.
- Sits between client logic and the UART TX core:
  - Latches one byte from the winning client.
  - Issues the single-cycle start strobe.
  - Tracks the transmitter's busy flag to frame completion.
  - Enforces an optional inter-frame idle gap.
- Detects a transmitter that never acknowledges a start.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter_if : client request/ack and TX-core handshake bundle
// Revision 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_i;
   logic [8*NUM_REQ-1:0] data_i;
   logic [NUM_REQ-1:0]   ack_o;
   logic [NUM_REQ-1:0]   grant_o;
   logic [7:0]           tx_data_o;
   logic                 tx_data_flag_o;
   logic                 tx_busy_i;
   logic                 busy_o;
   logic                 err_timeout_o;

   // master: the clients plus the TX core driving the arbiter
   modport master (
      output req_i, data_i, tx_busy_i,
      input  ack_o, grant_o, tx_data_o, tx_data_flag_o, busy_o, err_timeout_o
   );

   modport slave (
      input  req_i, data_i, tx_busy_i,
      output ack_o, grant_o, tx_data_o, tx_data_flag_o, busy_o, err_timeout_o
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one UART TX core among NUM_REQ clients
// Revision 1.0
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int GAP_CYC     = 0,
   parameter int TIMEOUT_CYC = 16
) (
   input  wire logic        sys_clk_i,
   input  wire logic        rst_n_i,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
   localparam logic [1:0] ST_WAIT_DONE = 2'd2;
   localparam logic [1:0] ST_GAP       = 2'd3;

   logic [1:0]         state;
   logic [1:0]         state_nx;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   win_idx;
   logic               win_valid;
   logic [NUM_REQ-1:0] win_onehot;
   logic [CNT_W-1:0]   cnt;

   // Search starts just past the previous owner so every client gets a turn.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = last_grant;
      cand      = last_grant;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
         if (!win_valid && bus.req_i[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
      win_onehot = NUM_REQ'(1) << win_idx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (win_valid) state_nx = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (bus.tx_busy_i)         state_nx = ST_WAIT_DONE;
            else if (cnt == TMO_LAST)  state_nx = ST_IDLE;
         end
         ST_WAIT_DONE: begin
            if (!bus.tx_busy_i) state_nx = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (!rst_n_i) begin
         state              <= ST_IDLE;
         last_grant         <= IDX_W'(NUM_REQ - 1);
         cnt                <= '0;
         bus.ack_o          <= '0;
         bus.grant_o        <= '0;
         bus.tx_data_o      <= '0;
         bus.tx_data_flag_o <= 1'b0;
         bus.busy_o         <= 1'b0;
         bus.err_timeout_o  <= 1'b0;
      end else begin
         state              <= state_nx;
         bus.busy_o         <= (state_nx != ST_IDLE);
         bus.ack_o          <= '0;
         bus.tx_data_flag_o <= 1'b0;
         bus.err_timeout_o  <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (win_valid) begin
                  bus.tx_data_o      <= bus.data_i[{win_idx, 3'b000} +: 8];
                  bus.tx_data_flag_o <= 1'b1;
                  bus.ack_o          <= win_onehot;
                  bus.grant_o        <= win_onehot;
                  last_grant         <= win_idx;
               end
            end
            ST_WAIT_BUSY: begin
               if (bus.tx_busy_i) begin
                  cnt <= '0;
               end else if (cnt == TMO_LAST) begin
                  // TX core never answered: drop the byte, no retry.
                  bus.err_timeout_o <= 1'b1;
                  bus.grant_o       <= '0;
                  cnt               <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               cnt <= '0;
               if (!bus.tx_busy_i) bus.grant_o <= '0;
            end
            ST_GAP: begin
               cnt <= (cnt == GAP_LAST) ? '0 : cnt + CNT_W'(1);
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// tb_uart_tx_arbiter : directed and randomized checks of uart_tx_arbiter against
// a timestamp-based transaction model.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int GAP = 5;
   localparam int TMO = 16;

   logic sys_clk_i = 1'b0;
   logic rst_n_i   = 1'b0;

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ    (N),
      .GAP_CYC    (GAP),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .sys_clk_i(sys_clk_i),
      .rst_n_i  (rst_n_i),
      .bus      (bus)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- TX core responder ----------------
   int tx_len  = 10;
   bit tx_dead = 1'b0;
   int left    = 0;

   initial begin
      bus.tx_busy_i = 1'b0;
      forever begin
         @(posedge sys_clk_i);
         #1;
         if (bus.tx_data_flag_o === 1'b1 && !tx_dead) left = tx_len;
         else if (left > 0) left--;
         bus.tx_busy_i = (left > 0);
      end
   end

   // ---------------- transaction model ----------------
   // Frames are tracked by edge timestamps: arbitration is allowed from arb_edge on.
   int           edge_n = 0;
   int           last_g, strobe_edge, arb_edge, c;
   bit           active, seen_busy, found;
   bit           model_valid = 1'b0;
   logic [N-1:0] e_ack, e_grant;
   logic [7:0]   e_data;
   logic         e_flag, e_busy, e_err;

   always @(posedge sys_clk_i) begin
      edge_n++;
      e_ack  = '0;
      e_flag = 1'b0;
      e_err  = 1'b0;
      if (rst_n_i !== 1'b1) begin
         e_grant   = '0;
         e_data    = '0;
         last_g    = N - 1;
         active    = 1'b0;
         seen_busy = 1'b0;
         arb_edge  = 0;
      end else if (active) begin
         if (!seen_busy) begin
            if (bus.tx_busy_i) seen_busy = 1'b1;
            else if (edge_n - strobe_edge == TMO) begin
               e_err    = 1'b1;
               e_grant  = '0;
               active   = 1'b0;
               arb_edge = edge_n + 1;
            end
         end else if (!bus.tx_busy_i) begin
            e_grant  = '0;
            active   = 1'b0;
            arb_edge = edge_n + GAP + 1;
         end
      end else if (edge_n >= arb_edge) begin
         found = 1'b0;
         for (int i = 1; i <= N; i++) begin
            c = (last_g + i) % N;
            if (!found && bus.req_i[c]) begin
               found       = 1'b1;
               e_flag      = 1'b1;
               e_ack       = N'(1) << c;
               e_grant     = e_ack;
               e_data      = bus.data_i[8*c +: 8];
               last_g      = c;
               active      = 1'b1;
               seen_busy   = 1'b0;
               strobe_edge = edge_n;
            end
         end
      end
      e_busy      = active || (edge_n + 1 < arb_edge);
      model_valid = 1'b1;
   end

   always @(negedge sys_clk_i) begin
      if (model_valid) begin
         chk("m_ack",   32'(bus.ack_o),          32'(e_ack));
         chk("m_grant", 32'(bus.grant_o),        32'(e_grant));
         chk("m_data",  32'(bus.tx_data_o),      32'(e_data));
         chk("m_flag",  32'(bus.tx_data_flag_o), 32'(e_flag));
         chk("m_busy",  32'(bus.busy_o),         32'(e_busy));
         chk("m_err",   32'(bus.err_timeout_o),  32'(e_err));
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge sys_clk_i);
      #2;
   endtask

   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.tx_data_flag_o !== 1'b1 && n < 300);
      chk("strobe_seen", 32'(bus.tx_data_flag_o), 32'd1);
   endtask

   task automatic wait_fall(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.tx_busy_i !== 1'b0 && n < 300);
      chk("busy_fall", 32'(bus.tx_busy_i), 32'd0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((bus.busy_o !== 1'b0 || bus.tx_busy_i !== 1'b0) && n < 300) begin
         tick();
         n++;
      end
      chk("idle", 32'(bus.busy_o), 32'd0);
   endtask

   task automatic reset_pulse();
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int n;
   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      bus.req_i  = '0;
      bus.data_i = '0;
      repeat (3) tick();
      chk("rst_ack",   32'(bus.ack_o),          32'd0);
      chk("rst_grant", 32'(bus.grant_o),        32'd0);
      chk("rst_data",  32'(bus.tx_data_o),      32'd0);
      chk("rst_flag",  32'(bus.tx_data_flag_o), 32'd0);
      chk("rst_busy",  32'(bus.busy_o),         32'd0);
      chk("rst_err",   32'(bus.err_timeout_o),  32'd0);
      rst_n_i = 1'b1;
      tick();

      // single request, long frame
      tx_len     = 100;
      bus.data_i = 32'h00A5_0000;
      bus.req_i  = 4'b0100;
      tick();
      chk("single_flag",  32'(bus.tx_data_flag_o), 32'd1);
      chk("single_data",  32'(bus.tx_data_o),      32'hA5);
      chk("single_ack",   32'(bus.ack_o),          32'b0100);
      chk("single_grant", 32'(bus.grant_o),        32'b0100);
      bus.req_i = '0;
      wait_fall(n);
      chk("single_len",       32'(n), 32'd100);
      chk("single_grant_end", 32'(bus.grant_o), 32'b0100);
      tick();
      chk("single_grant_off", 32'(bus.grant_o), 32'd0);
      chk("single_gap_busy",  32'(bus.busy_o),  32'd1);
      repeat (4) tick();
      chk("single_gap_last",  32'(bus.busy_o),  32'd1);
      tick();
      chk("single_idle",      32'(bus.busy_o),  32'd0);

      // contention from reset: order 0,1,2,3,0 with a 7-cycle fall-to-strobe gap
      tx_len = 10;
      reset_pulse();
      bus.data_i = 32'h4433_2211;
      bus.req_i  = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         wait_strobe(n);
         if (f > 0) chk("gap_latency", 32'(n), 32'd7);
         chk("rr_grant", 32'(bus.grant_o),   32'd1 << order[f]);
         chk("rr_ack",   32'(bus.ack_o),     32'd1 << order[f]);
         chk("rr_data",  32'(bus.tx_data_o), 32'h11 * (order[f] + 1));
         wait_fall(n);
      end
      bus.req_i = '0;
      wait_idle();

      // fairness after reset: client 3 first, then 0 beats 3
      reset_pulse();
      bus.req_i = 4'b1000;
      wait_strobe(n);
      chk("fair_first", 32'(bus.grant_o), 32'b1000);
      bus.req_i = 4'b1001;
      wait_fall(n);
      wait_strobe(n);
      chk("fair_second", 32'(bus.grant_o), 32'b0001);
      bus.req_i = '0;
      wait_fall(n);
      wait_idle();

      // start timeout with a dead TX core
      tx_dead   = 1'b1;
      bus.req_i = 4'b0001;
      wait_strobe(n);
      bus.req_i = '0;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.err_timeout_o !== 1'b1 && n < 40);
      chk("tmo_latency", 32'(n), 32'd16);
      chk("tmo_grant",   32'(bus.grant_o), 32'd0);
      chk("tmo_busy",    32'(bus.busy_o),  32'd0);
      tx_dead   = 1'b0;
      bus.req_i = 4'b0010;
      wait_strobe(n);
      chk("tmo_recover", 32'(bus.ack_o), 32'b0010);
      bus.req_i = '0;
      wait_fall(n);
      wait_idle();

      // reset in the middle of a frame
      tx_len    = 50;
      bus.req_i = 4'b0100;
      wait_strobe(n);
      bus.req_i = '0;
      repeat (3) tick();
      rst_n_i   = 1'b0;
      bus.req_i = 4'b1011;
      tick();
      chk("mid_grant", 32'(bus.grant_o),        32'd0);
      chk("mid_busy",  32'(bus.busy_o),         32'd0);
      chk("mid_flag",  32'(bus.tx_data_flag_o), 32'd0);
      chk("mid_data",  32'(bus.tx_data_o),      32'd0);
      rst_n_i = 1'b1;
      wait_strobe(n);
      chk("mid_first", 32'(bus.grant_o), 32'b0001);
      bus.req_i[0] = 1'b0;

      // randomized traffic
      for (int it = 0; it < 3000; it++) begin
         tick();
         tx_len  = int'($urandom_range(1, 8));
         tx_dead = ($urandom % 8) == 0;
         rst_n_i = ($urandom % 500) != 0;
         for (int k = 0; k < N; k++) begin
            if (bus.ack_o[k] === 1'b1) begin
               bus.req_i[k]         = 1'($urandom % 2);
               bus.data_i[8*k +: 8] = 8'($urandom);
            end else if (!bus.req_i[k] && ($urandom % 4) == 0) begin
               bus.req_i[k]         = 1'b1;
               bus.data_i[8*k +: 8] = 8'($urandom);
            end
         end
      end
      rst_n_i   = 1'b1;
      tx_dead   = 1'b0;
      bus.req_i = '0;
      repeat (2) tick();
      wait_idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
